vga_frame_regs: RTL and testbench
=================================

# vga_frame_regs

Frame-synchronised register bank between the Avalon-MM slave port and the VGA sprite/background renderer. CPU writes land in shadow registers. They are copied to the active registers the renderer consumes only at the start of vertical blank. This keeps a frame from tearing when boundaries or sprite positions change. The block also provides a frame counter, status readback and a level interrupt that tells the driver a commit has completed.

## Interface
- VACTIVE, 480: first non-visible line; commit point is hcount==0 && vcount==VACTIVE.
- NREG, 13: number of shadow/active register pairs (addresses 0..NREG-1).
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high.
- chipselect  in  1  Avalon select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  6  Avalon word address.
- writedata  in  16  Avalon write data.
- readdata  out  16  registered read data.
- hcount  in  11  from vga_counters.
- vcount  in  10  from vga_counters.
- boundary_1..boundary_4  out  10 each  active river boundaries (addr 0–3).
- sprite{1,2,3}_x  out  10  active sprite x (addr 4, 7, 10).
- sprite{1,2,3}_y  out  10  active sprite y; bit 0 = on-screen (addr 5, 8, 11).
- sprite{1,2}_img  out  5  active sprite image select (addr 6, 9).
- sprite3_img  out  5  addr 12.
- irq  out  1  commit-done interrupt, level.

## Operation
- Shadow write: chipselect&&write with address<NREG stores writedata, truncated to the target width, into shadow[address]. Active outputs do not change.
- CTRL at 0x20, write only. bit0 = ARM sets pending. bit1 = AUTO, stored as given on every CTRL write. bit2 = IRQ_CLR clears irq.
- STATUS at 0x21, read. {frame_cnt[7:0], 5'b0, irq, auto, pending}.
- Writes to unmapped addresses are ignored. Reads of unmapped addresses return 0.
- Reads at 0..NREG-1 return the zero-extended shadow value, not the active value.
- frame_start = (hcount==0 && vcount==VACTIVE). It is a single-cycle pulse once per frame.
- On frame_start:
  - frame_cnt increments, 8-bit, wraps 255→0.
  - If pending||auto: all active registers ← shadow, pending←0, irq←1.
- State: IDLE (pending=0) → ARMED (pending=1) on ARM write. ARMED → IDLE on frame_start, with commit. In AUTO mode the commit happens on every frame_start regardless of state.
- Simultaneous events, all resolved deterministically:
  - Shadow write on the frame_start cycle: the commit copies the pre-write shadow value. The new value waits for the next commit.
  - ARM write on the frame_start cycle: the current commit proceeds if already pending/auto. pending ends at 1, so the next frame commits again.
  - IRQ_CLR on a commit cycle: the set wins, irq=1.
- Reset mid-frame: everything returns to reset values immediately. No commit occurs until the next frame_start with pending or auto set.

## Timing
- Reset values:
  - All shadow and active registers 0, so all sprites are off-screen because y[0]=0.
  - pending=0, auto=0, irq=0, frame_cnt=0, readdata=0.
- Write latency: shadow/CTRL state updates on the clock edge that samples the write.
- Read latency: readdata is valid 1 cycle after chipselect&&read. It holds its value until the next read.
- Commit latency: active outputs change on the clock edge that samples frame_start. They are stable for the whole visible area of the following frame.
- Active outputs are registered and never change outside the frame_start edge or reset.
- irq rises on the same edge as the commit. It stays high until an IRQ_CLR write.
- Area target: ~150–250 lines RTL, with no multipliers.

## Test plan
- Reset, then write addr 4 = 0x0123 → sprite1_x stays 0. Read addr 4 one cycle later returns 0x0123.
- Write addr 0 = 200, addr 1 = 400, then CTRL=0x1. Run to vcount=480/hcount=0 → boundary_1=200 and boundary_2=400 on that edge. pending=0, irq=1, STATUS=0x0104.
- AUTO: write CTRL=0x2, then write addr 5 = 0x0151 mid-frame → sprite1_y=0x151 at the next frame_start. frame_cnt increments every frame and wraps after 256 frames.
- Same-cycle shadow write at frame_start with pending=1: write addr 0 = 50 (old shadow 10) → boundary_1=10 after this commit, 50 after the next armed commit.
- Same-cycle IRQ_CLR and commit → irq=1. A subsequent IRQ_CLR alone → irq=0. Assert async reset mid-frame with pending=1 → all outputs 0, no commit at the next frame_start.

Source files
------------

// File: rtl/vga_frame_regs_if.sv
// Avalon-MM slave bus between the CPU and the VGA frame register bank.
interface vga_frame_regs_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [5:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/vga_frame_regs.sv
// Frame-synchronised shadow/active register bank for the VGA renderer.
// Shadow values commit to the active outputs only at the start of vertical blank.
module vga_frame_regs #(
    parameter int unsigned VACTIVE = 480,
    parameter int unsigned NREG    = 13
) (
    input  logic             clk,
    input  logic             reset,
    vga_frame_regs_if.slave  avalon,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    output logic [9:0]       boundary_1,
    output logic [9:0]       boundary_2,
    output logic [9:0]       boundary_3,
    output logic [9:0]       boundary_4,
    output logic [9:0]       sprite1_x,
    output logic [9:0]       sprite1_y,
    output logic [4:0]       sprite1_img,
    output logic [9:0]       sprite2_x,
    output logic [9:0]       sprite2_y,
    output logic [4:0]       sprite2_img,
    output logic [9:0]       sprite3_x,
    output logic [9:0]       sprite3_y,
    output logic [4:0]       sprite3_img,
    output logic             irq
);

    localparam int unsigned AW       = $clog2(NREG);
    localparam logic [9:0]  VACT     = 10'(VACTIVE);
    localparam logic [5:0]  NREG_A   = 6'(NREG);
    localparam logic [5:0]  ADDR_CTL = 6'h20;
    localparam logic [5:0]  ADDR_STS = 6'h21;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t      state;
    logic        auto_mode;
    logic [7:0]  frame_cnt;
    logic [9:0]  shadow [NREG];
    logic [9:0]  active [NREG];

    logic          frame_start;
    logic          commit;
    logic          bus_wr;
    logic          bus_rd;
    logic          ctrl_wr;
    logic          shadow_wr;
    logic [AW-1:0] idx;
    logic [9:0]    wr_val;

    assign frame_start = (hcount == 11'd0) && (vcount == VACT);
    assign commit      = frame_start && ((state == ARMED) || auto_mode);
    assign bus_wr      = avalon.chipselect && avalon.write;
    assign bus_rd      = avalon.chipselect && avalon.read;
    assign ctrl_wr     = bus_wr && (avalon.address == ADDR_CTL);
    assign shadow_wr   = bus_wr && (avalon.address < NREG_A);
    assign idx         = avalon.address[AW-1:0];

    // Image-select registers are 5 bits wide; keep their upper shadow bits zero
    always_comb begin
        wr_val = avalon.writedata[9:0];
        if (avalon.address == 6'd6 || avalon.address == 6'd9 || avalon.address == 6'd12)
            wr_val = {5'b0, avalon.writedata[4:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            auto_mode       <= 1'b0;
            irq             <= 1'b0;
            frame_cnt       <= '0;
            avalon.readdata <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (shadow_wr)
                shadow[idx] <= wr_val;

            // Non-blocking copy picks up the pre-write shadow on a same-cycle write
            if (commit) begin
                for (int unsigned i = 0; i < NREG; i++)
                    active[i] <= shadow[i];
            end

            if (frame_start)
                frame_cnt <= frame_cnt + 8'd1;

            if (commit)
                irq <= 1'b1;
            else if (ctrl_wr && avalon.writedata[2])
                irq <= 1'b0;

            if (ctrl_wr)
                auto_mode <= avalon.writedata[1];

            case (state)
                IDLE:  if (ctrl_wr && avalon.writedata[0]) state <= ARMED;
                ARMED: if (frame_start && !(ctrl_wr && avalon.writedata[0])) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (bus_rd) begin
                if (avalon.address < NREG_A)
                    avalon.readdata <= {6'b0, shadow[idx]};
                else if (avalon.address == ADDR_STS)
                    avalon.readdata <= {frame_cnt, 5'b0, irq, auto_mode, state == ARMED};
                else
                    avalon.readdata <= '0;
            end
        end
    end

    assign boundary_1  = active[0];
    assign boundary_2  = active[1];
    assign boundary_3  = active[2];
    assign boundary_4  = active[3];
    assign sprite1_x   = active[4];
    assign sprite1_y   = active[5];
    assign sprite1_img = active[6][4:0];
    assign sprite2_x   = active[7];
    assign sprite2_y   = active[8];
    assign sprite2_img = active[9][4:0];
    assign sprite3_x   = active[10];
    assign sprite3_y   = active[11];
    assign sprite3_img = active[12][4:0];

    logic unused_bits;
    assign unused_bits = ^{active[6][9:5], active[9][9:5], active[12][9:5],
                           avalon.writedata[15:10]};

endmodule

// File: tb/tb_vga_frame_regs.sv
// Scoreboard bench for vga_frame_regs: stimulus queues expectations, a monitor pops and compares.
module tb_vga_frame_regs;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    vga_frame_regs_if bus();
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [9:0]  boundary_1, boundary_2, boundary_3, boundary_4;
    logic [9:0]  sprite1_x, sprite1_y, sprite2_x, sprite2_y, sprite3_x, sprite3_y;
    logic [4:0]  sprite1_img, sprite2_img, sprite3_img;
    logic        irq;

    vga_frame_regs #(.VACTIVE(480), .NREG(13)) dut (
        .clk(clk), .reset(reset), .avalon(bus),
        .hcount(hcount), .vcount(vcount),
        .boundary_1(boundary_1), .boundary_2(boundary_2),
        .boundary_3(boundary_3), .boundary_4(boundary_4),
        .sprite1_x(sprite1_x), .sprite1_y(sprite1_y), .sprite1_img(sprite1_img),
        .sprite2_x(sprite2_x), .sprite2_y(sprite2_y), .sprite2_img(sprite2_img),
        .sprite3_x(sprite3_x), .sprite3_y(sprite3_y), .sprite3_img(sprite3_img),
        .irq(irq)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } item_t;

    item_t sbq[$];
    int    checks   = 0;
    int    failures = 0;
    int    frames   = 0;
    logic  rd_seen  = 1'b0;
    logic  chk_req  = 1'b0;

    // sel 0 = readdata, 1..13 = active register by address+1, 14 = irq
    function automatic logic [15:0] observe(input int sel);
        case (sel)
            0:  return bus.readdata;
            1:  return {6'b0, boundary_1};
            2:  return {6'b0, boundary_2};
            3:  return {6'b0, boundary_3};
            4:  return {6'b0, boundary_4};
            5:  return {6'b0, sprite1_x};
            6:  return {6'b0, sprite1_y};
            7:  return {11'b0, sprite1_img};
            8:  return {6'b0, sprite2_x};
            9:  return {6'b0, sprite2_y};
            10: return {11'b0, sprite2_img};
            11: return {6'b0, sprite3_x};
            12: return {6'b0, sprite3_y};
            13: return {11'b0, sprite3_img};
            14: return {15'b0, irq};
            default: return 16'hDEAD;
        endcase
    endfunction

    always @(posedge clk) rd_seen <= bus.chipselect && bus.read;

    always @(negedge clk) begin
        item_t it;
        int    n;
        n = int'(rd_seen) + int'(chk_req);
        for (int k = 0; k < n; k++) begin
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: output presented with no expectation queued");
            end else begin
                it = sbq.pop_front();
                checks++;
                if (observe(it.sel) !== it.exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%04h expected 0x%04h", it.name, observe(it.sel), it.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic fs, input logic wr, input logic rd,
                       input logic [5:0] a, input logic [15:0] d);
        bus.chipselect = wr | rd;
        bus.write      = wr;
        bus.read       = rd;
        bus.address    = a;
        bus.writedata  = d;
        if (fs) begin
            hcount = 11'd0;
            vcount = 10'd480;
            frames++;
        end
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        hcount         = 11'd5;
        vcount         = 10'd100;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input string name, input logic [5:0] a, input logic [15:0] exp);
        item_t it;
        it.name = name; it.sel = 0; it.exp = exp;
        sbq.push_back(it);
        cyc(1'b0, 1'b0, 1'b1, a, 16'h0);
    endtask

    task automatic frame();
        cyc(1'b1, 1'b0, 1'b0, 6'h0, 16'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
    endtask

    task automatic expect_out(input string name, input int sel, input logic [15:0] exp);
        item_t it;
        it.name = name; it.sel = sel; it.exp = exp;
        sbq.push_back(it);
        chk_req = 1'b1;
        tick();
        chk_req = 1'b0;
    endtask

    function automatic logic [15:0] st(input logic i, input logic au, input logic p);
        return {8'(frames), 5'b0, i, au, p};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = '0; bus.writedata = '0;
        hcount = 11'd5; vcount = 10'd100;
        repeat (3) tick();
        reset = 1'b0;
        frames = 0;

        expect_out("reset_readdata", 0, 16'h0);
        expect_out("reset_irq", 14, 16'h0);
        expect_out("reset_sprite1_y", 6, 16'h0);
        expect_out("reset_boundary_1", 1, 16'h0);
        rd("reset_status", 6'h21, 16'h0000);

        wr(6'd4, 16'h0123);
        expect_out("shadow_write_no_active", 5, 16'h0);
        rd("shadow_readback", 6'd4, 16'h0123);

        wr(6'd12, 16'h00FF);
        rd("img_truncate", 6'd12, 16'h001F);
        wr(6'h30, 16'hFFFF);
        rd("unmapped_read", 6'h30, 16'h0);
        rd("ctrl_read_zero", 6'h20, 16'h0);
        wr(6'd3, 16'hFFFF);
        rd("boundary_truncate", 6'd3, 16'h03FF);

        wr(6'd0, 16'd200);
        wr(6'd1, 16'd400);
        wr(6'h20, 16'h0001);
        rd("status_armed", 6'h21, st(1'b0, 1'b0, 1'b1));
        expect_out("armed_no_commit_yet", 1, 16'h0);
        frame();
        expect_out("commit_boundary_1", 1, 16'd200);
        expect_out("commit_boundary_2", 2, 16'd400);
        expect_out("commit_sprite1_x", 5, 16'h0123);
        expect_out("commit_sprite3_img", 13, 16'h001F);
        expect_out("commit_boundary_4", 4, 16'h03FF);
        expect_out("commit_irq", 14, 16'h1);
        rd("status_after_commit", 6'h21, 16'h0104);

        wr(6'd0, 16'd10);
        wr(6'h20, 16'h0001);
        cyc(1'b1, 1'b1, 1'b0, 6'h20, 16'h0004);
        expect_out("irqclr_vs_commit_irq", 14, 16'h1);
        expect_out("irqclr_vs_commit_b1", 1, 16'd10);
        rd("status_after_clr_commit", 6'h21, 16'h0204);
        wr(6'h20, 16'h0004);
        expect_out("irqclr_alone", 14, 16'h0);

        wr(6'h20, 16'h0001);
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 16'd50);
        expect_out("same_cycle_write_old", 1, 16'd10);
        rd("same_cycle_write_shadow", 6'd0, 16'd50);
        wr(6'h20, 16'h0001);
        frame();
        expect_out("same_cycle_write_next", 1, 16'd50);

        wr(6'd1, 16'd300);
        cyc(1'b1, 1'b1, 1'b0, 6'h20, 16'h0001);
        expect_out("arm_on_fs_idle_no_commit", 2, 16'd400);
        rd("arm_on_fs_idle_status", 6'h21, 16'h0505);
        frame();
        expect_out("arm_on_fs_idle_next", 2, 16'd300);

        wr(6'h20, 16'h0001);
        wr(6'd1, 16'd350);
        cyc(1'b1, 1'b1, 1'b0, 6'h20, 16'h0001);
        expect_out("arm_on_fs_pending_commit", 2, 16'd350);
        rd("arm_on_fs_pending_status", 6'h21, 16'h0705);
        wr(6'd1, 16'd360);
        frame();
        expect_out("arm_on_fs_pending_next", 2, 16'd360);

        wr(6'h20, 16'h0002);
        wr(6'd5, 16'h0151);
        expect_out("auto_before_fs", 6, 16'h0);
        frame();
        expect_out("auto_commit", 6, 16'h0151);
        rd("auto_status", 6'h21, 16'h0906);
        wr(6'h20, 16'h0006);
        expect_out("auto_irqclr", 14, 16'h0);
        wr(6'd5, 16'h0153);
        frame();
        expect_out("auto_commit_again", 6, 16'h0153);
        expect_out("auto_commit_irq", 14, 16'h1);
        repeat (256) frame();
        rd("frame_cnt_wrap", 6'h21, 16'h0A06);

        wr(6'h20, 16'h0001);
        wr(6'd0, 16'd77);
        rd("pre_reset_read", 6'd0, 16'd77);
        idle();
        #4 reset = 1'b1;
        expect_out("async_reset_readdata", 0, 16'h0);
        expect_out("async_reset_b1", 1, 16'h0);
        expect_out("async_reset_b2", 2, 16'h0);
        expect_out("async_reset_s1y", 6, 16'h0);
        expect_out("async_reset_irq", 14, 16'h0);
        reset = 1'b0;
        frames = 0;
        frame();
        expect_out("post_reset_no_commit_b1", 1, 16'h0);
        expect_out("post_reset_no_commit_irq", 14, 16'h0);
        rd("post_reset_status", 6'h21, 16'h0100);

        idle();
        idle();
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
